div_seq_ctrl: RTL and testbench

Sequencer that owns the iterative 64-bit divider core and presents it to the EX stage as a DIV/DIVU unit. It accepts one request at a time and strips signs before launching the unsigned core. It applies MIPS sign fix-up to the core result, handles divide-by-zero without using the core, and writes HI/LO. It also stalls the pipeline while busy and supports flush (abort) and a core-timeout watchdog.

---
 rtl/div_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_div_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencer wrapping an iterative unsigned divider core as a
// MIPS DIV/DIVU unit. Strips operand signs before launching the core, applies
// the sign fix-up on the way back, short-circuits divide-by-zero, writes HI/LO,
// stalls the pipeline while busy, and supports flush and a core watchdog.
module div_seq_ctrl #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             req_ready,
  input  logic             flush,
  output logic             stall,
  output logic             core_start,
  output logic [WIDTH-1:0] core_dividend,
  output logic [WIDTH-1:0] core_divisor,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_quotient,
  input  logic [WIDTH-1:0] core_remainder,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             dbz,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FIXUP,
    S_DRAIN
  } state_t;

  // Watchdog fires on the last allowed WAIT/DRAIN cycle, so the state lasts
  // exactly TIMEOUT cycles and err appears TIMEOUT cycles after entry.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] q_r, r_r;
  logic             sign_q, sign_r, dbz_pend;
  logic             accept, timed_out;
  logic             cnt_clr, capture, writeback, raise_err;

  // flush in IDLE blocks acceptance for that cycle.
  assign accept     = (state == S_IDLE) && req_valid && !flush;
  assign timed_out  = (cnt == CNT_LAST);
  assign req_ready  = (state == S_IDLE);
  assign stall      = (state != S_IDLE);
  assign core_start = (state == S_LAUNCH);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle control strobes.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    capture   = 1'b0;
    writeback = 1'b0;
    raise_err = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = (req_b == '0) ? S_FIXUP : S_LAUNCH;
      end
      S_LAUNCH: begin
        cnt_clr   = 1'b1;
        state_nxt = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          // A result arriving with the flush already ends the core run.
          cnt_clr   = 1'b1;
          state_nxt = core_done ? S_IDLE : S_DRAIN;
        end else if (core_done) begin
          capture   = 1'b1;
          state_nxt = S_FIXUP;
        end else if (timed_out) begin
          raise_err = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_FIXUP: begin
        writeback = !flush;
        state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (core_done || timed_out) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Watchdog counter: cleared on launch/flush, counts WAIT and DRAIN cycles.
  always_ff @(posedge clk) begin
    if (rst)                                     cnt <= '0;
    else if (cnt_clr)                            cnt <= '0;
    else if (state == S_WAIT || state == S_DRAIN) cnt <= cnt + 8'd1;
  end

  // Operand latch, result capture, sign fix-up and HI/LO writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_dividend <= '0;
      core_divisor  <= '0;
      q_r           <= '0;
      r_r           <= '0;
      sign_q        <= 1'b0;
      sign_r        <= 1'b0;
      dbz_pend      <= 1'b0;
      hi            <= '0;
      lo            <= '0;
      done          <= 1'b0;
      dbz           <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= raise_err;
      if (accept) begin
        core_dividend <= (req_signed && req_a[WIDTH-1]) ? -req_a : req_a;
        core_divisor  <= (req_signed && req_b[WIDTH-1]) ? -req_b : req_b;
        // Preload the divide-by-zero result; a core capture overwrites it.
        // Signs are cleared for dbz so FIXUP passes these through untouched.
        q_r      <= '1;
        r_r      <= req_a;
        dbz_pend <= (req_b == '0);
        sign_q   <= req_signed && (req_b != '0) && (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
        sign_r   <= req_signed && (req_b != '0) && req_a[WIDTH-1];
      end
      if (capture) begin
        q_r <= core_quotient;
        r_r <= core_remainder;
      end
      if (writeback) begin
        lo   <= sign_q ? -q_r : q_r;
        hi   <= sign_r ? -r_r : r_r;
        dbz  <= dbz_pend;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed cases plus randomized
// DIV/DIVU requests, with a behavioural divider core and reference model.
module tb_div_seq_ctrl;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_signed;
  logic [W-1:0] req_a, req_b;
  logic         req_ready, flush, stall, core_start;
  logic [W-1:0] core_dividend, core_divisor;
  logic         core_done;
  logic [W-1:0] core_quotient, core_remainder;
  logic [W-1:0] hi, lo;
  logic         done, dbz, err;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_hi, exp_lo;
  logic         exp_dbz;

  div_seq_ctrl #(.WIDTH(W), .TIMEOUT(80)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_signed(req_signed),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .flush(flush), .stall(stall),
    .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_done(core_done), .core_quotient(core_quotient), .core_remainder(core_remainder),
    .hi(hi), .lo(lo), .done(done), .dbz(dbz), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // MIPS DIV/DIVU semantics in plain arithmetic (truncating division,
  // remainder takes the dividend's sign).
  function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo_e, output logic [W-1:0] hi_e);
    if (b == '0) begin
      lo_e = '1;
      hi_e = a;
    end else if (!s) begin
      lo_e = a / b;
      hi_e = a % b;
    end else if (a == 64'h8000_0000_0000_0000 && b == '1) begin
      lo_e = a;
      hi_e = '0;
    end else begin
      lo_e = W'($signed(a) / $signed(b));
      hi_e = W'($signed(a) % $signed(b));
    end
  endfunction

  // One complete request; the bench plays the core, answering lat cycles after launch.
  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    logic [W-1:0] lo_e, hi_e, dvd_e, dvs_e;
    ref_div(s, a, b, lo_e, hi_e);
    dvd_e = (s && a[W-1]) ? 64'd0 - a : a;
    dvs_e = (s && b[W-1]) ? 64'd0 - b : b;
    check("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_signed = s; req_a = a; req_b = b;
    step();
    req_valid = 1'b0; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    if (b == '0) begin
      check("dbz_no_start", core_start, 0);
      check("dbz_stall", stall, 1);
    end else begin
      check("launch_start", core_start, 1);
      check("launch_dividend", core_dividend, dvd_e);
      check("launch_divisor", core_divisor, dvs_e);
      for (int i = 0; i < lat; i++) begin
        step();
        if (i == 0) check("start_single_cycle", core_start, 0);
      end
      check("wait_dividend_held", core_dividend, dvd_e);
      core_done = 1'b1; core_quotient = dvd_e / dvs_e; core_remainder = dvd_e % dvs_e;
      step();
      core_done = 1'b0; core_quotient = {$urandom, $urandom}; core_remainder = {$urandom, $urandom};
      check("fixup_no_done", done, 0);
      check("fixup_stall", stall, 1);
    end
    step();
    check("done_pulse", done, 1);
    check("lo_result", lo, lo_e);
    check("hi_result", hi, hi_e);
    check("dbz_flag", dbz, (b == '0));
    check("done_no_stall", stall, 0);
    exp_lo = lo_e; exp_hi = hi_e; exp_dbz = (b == '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hi"}, hi, 0);
    check({tag, "_lo"}, lo, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_dbz"}, dbz, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_start"}, core_start, 0);
    check({tag, "_dividend"}, core_dividend, 0);
    check({tag, "_divisor"}, core_divisor, 0);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_ready"}, req_ready, 1);
  endtask

  initial begin
    logic         seen, s;
    logic [W-1:0] a, b;

    rst = 1'b1; req_valid = 1'b0; req_signed = 1'b0; req_a = '0; req_b = '0;
    flush = 1'b0; core_done = 1'b0; core_quotient = '0; core_remainder = '0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    step();

    // Signed -7 / 2, core answers after 65 cycles.
    do_op(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65);
    check("neg7_lo_const", lo, 64'hFFFF_FFFF_FFFF_FFFD);
    check("neg7_hi_const", hi, 64'hFFFF_FFFF_FFFF_FFFF);

    // DIVU all-ones / 16, back-to-back with the previous done cycle.
    do_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 3);
    check("divu_lo_const", lo, 64'h0FFF_FFFF_FFFF_FFFF);
    check("divu_hi_const", hi, 64'hF);

    // Divide by zero: no core launch, done at T+2.
    do_op(1'b0, 64'h1234, 64'd0, 1);
    check("dbz_lo_const", lo, 64'hFFFF_FFFF_FFFF_FFFF);
    check("dbz_hi_const", hi, 64'h1234);

    // Signed overflow -2^63 / -1.
    do_op(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    check("ovf_lo_const", lo, 64'h8000_0000_0000_0000);
    check("ovf_hi_const", hi, 64'h0);

    // Flush in FIXUP on a divide-by-zero: writeback suppressed.
    req_valid = 1'b1; req_signed = 1'b1; req_a = 64'h55; req_b = '0;
    step();
    req_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_fixup_no_done", done, 0);
    check("flush_fixup_lo", lo, exp_lo);
    check("flush_fixup_hi", hi, exp_hi);
    check("flush_fixup_dbz_held", dbz, exp_dbz);
    check("flush_fixup_idle", stall, 0);
    step();

    // Flush in WAIT, core_done 10 cycles later ends DRAIN.
    req_valid = 1'b1; req_signed = 1'b0; req_a = 64'd100; req_b = 64'd7;
    step();
    req_valid = 1'b0;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("drain_stall", stall, 1);
    seen = done;
    repeat (9) begin
      step();
      seen = seen | done | ~stall;
    end
    core_done = 1'b1; core_quotient = 64'd14; core_remainder = 64'd2;
    step();
    core_done = 1'b0;
    check("drain_no_done_or_early_exit", seen, 0);
    check("drain_exit_stall", stall, 0);
    check("drain_exit_done", done, 0);
    check("drain_lo", lo, exp_lo);
    check("drain_hi", hi, exp_hi);
    do_op(1'b1, 64'hFFFF_FFFF_FFFF_FF00, 64'd9, 4);

    // Watchdog: core never answers.
    req_valid = 1'b1; req_signed = 1'b0; req_a = 64'd1000; req_b = 64'd3;
    step();
    req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step();
      seen = seen | err | ~stall;
    end
    check("timeout_early", seen, 0);
    step();
    check("timeout_err", err, 1);
    check("timeout_ready", req_ready, 1);
    check("timeout_no_done", done, 0);
    check("timeout_lo", lo, exp_lo);
    check("timeout_hi", hi, exp_hi);
    step();
    check("timeout_err_single", err, 0);

    // Reset in the middle of WAIT.
    req_valid = 1'b1; req_signed = 1'b1; req_a = 64'hFFFF_FFFF_0000_0000; req_b = 64'hFFFF_FFFF_FFFF_FFF0;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    step();

    // Randomized requests.
    for (int n = 0; n < 24; n++) begin
      s = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) b = '0;
      if ($urandom_range(0, 11) == 0) begin
        a = 64'h8000_0000_0000_0000;
        b = '1;
      end
      do_op(s, a, b, int'($urandom_range(1, 6)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
